encoder_param_controller: RTL and testbench

Sequences user parameter editing from the quadrature decoder's outputs. It converts position changes into detent steps and runs a browse/edit/commit state machine driven by steps and button pulses. Committed values are held in a local register bank and pushed to downstream configuration logic over a valid/ready write port. It sits between the decoder and the system's configuration registers.

---
 rtl/encoder_param_controller_pkg.sv | 32 +++
 rtl/encoder_param_controller_if.sv | 16 +
 rtl/encoder_param_controller_detent_stepper.sv | 79 +++++++
 rtl/encoder_param_controller.sv | 176 +++++++++++++++++
 tb/tb_encoder_param_controller.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/encoder_param_controller_pkg.sv
// Shared types for the encoder parameter controller.
//   state_t    : browse / edit / commit sequencing states
//   step_dir_t : per-cycle detent step direction (none / up / down)
package encoder_param_controller_pkg;

    typedef enum logic [1:0] {
        ST_BROWSE = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } step_dir_t;

    // Collapse the two step strobes into one direction code; up wins if both
    // were ever asserted together.
    function automatic step_dir_t step_dir(input logic up, input logic dn);
        step_dir_t d;
        if (up) begin
            d = DIR_UP;
        end else if (dn) begin
            d = DIR_DN;
        end else begin
            d = DIR_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/encoder_param_controller_if.sv
// Configuration write port: valid/ready handshake carrying one parameter
// write (index + value) toward the system configuration registers.
//   master : controller side (drives valid/addr/data, samples ready)
//   slave  : configuration-register side
interface encoder_param_controller_if #(
    parameter int IW     = 2,
    parameter int DATA_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [IW-1:0]     cfg_addr;
    logic [DATA_W-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/encoder_param_controller_detent_stepper.sv
// Converts a wrapping 16-bit decoder position into detent steps.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   position          : signed decoder count (two's complement, wraps)
//   clear             : zero the accumulator (state change in the controller)
//   step_up / step_dn : one-cycle step strobes, at most one per cycle
module detent_stepper
    import encoder_param_controller_pkg::*;
#(
    parameter int COUNTS_PER_DETENT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] position,
    input  logic        clear,
    output logic        step_up,
    output logic        step_dn
);

    localparam logic signed [7:0]  CPD   = 8'(COUNTS_PER_DETENT);
    localparam logic signed [15:0] CPD_W = 16'(COUNTS_PER_DETENT);

    logic [15:0]       pos_prev_r;
    logic              primed_r;
    logic signed [7:0] acc_r;
    logic signed [7:0] acc_next_s;
    logic [15:0]       delta_s;
    logic signed [15:0] sum_s;

    // Step strobes come straight from the registered accumulator so a count
    // crossing the threshold in cycle N steps in N+1 and lands in N+2.
    always_comb begin
        step_up = (acc_r >= CPD);
        step_dn = (acc_r <= -CPD);
    end

    // Modular delta, detent consumption and clamp into the 8-bit accumulator.
    always_comb begin
        if (primed_r) begin
            delta_s = position - pos_prev_r;
        end else begin
            delta_s = 16'd0;
        end
        sum_s = {{8{acc_r[7]}}, acc_r} + delta_s;
        if (step_up) begin
            sum_s = sum_s - CPD_W;
        end else if (step_dn) begin
            sum_s = sum_s + CPD_W;
        end else begin
            sum_s = sum_s;
        end
        // Large jumps clamp rather than wrap so direction is never inverted.
        if (sum_s > 16'sd127) begin
            acc_next_s = 8'sd127;
        end else if (sum_s < -16'sd128) begin
            acc_next_s = 8'sh80;
        end else begin
            acc_next_s = sum_s[7:0];
        end
    end

    // Position history and accumulator; first cycle after reset only primes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_prev_r <= 16'd0;
            primed_r   <= 1'b0;
            acc_r      <= 8'sd0;
        end else begin
            pos_prev_r <= position;
            primed_r   <= 1'b1;
            if (clear) begin
                acc_r <= 8'sd0;
            end else begin
                acc_r <= acc_next_s;
            end
        end
    end

endmodule

// File: rtl/encoder_param_controller.sv
// Browse/edit/commit sequencer for user-editable parameters driven by a
// rotary encoder and a button. Committed values live in a local bank and
// are written downstream over the cfg valid/ready port.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   position     : decoder count;  btn_pulse : one-cycle button press
//   sel_index    : selected parameter;  edit_active : high while editing
//   edit_value   : working value in EDIT, else the selected parameter
//   param_bus    : committed values, parameter i at [i*DATA_W +: DATA_W]
//   cfg          : write port (master side)
module encoder_param_controller
    import encoder_param_controller_pkg::*;
#(
    parameter  int NUM_PARAMS        = 4,
    parameter  int DATA_W            = 8,
    parameter  int PARAM_MAX         = 255,
    parameter  int COUNTS_PER_DETENT = 4,
    parameter  int TIMEOUT_CYCLES    = 50000000,
    localparam int IW                = $clog2(NUM_PARAMS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  position,
    input  logic                         btn_pulse,
    output logic [IW-1:0]                sel_index,
    output logic                         edit_active,
    output logic [DATA_W-1:0]            edit_value,
    output logic [NUM_PARAMS*DATA_W-1:0] param_bus,
    encoder_param_controller_if.master   cfg
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t            state_r, state_next_s;
    step_dir_t         dir_s;
    logic              step_up_s, step_dn_s, clear_s, hs_s;
    logic [IW-1:0]     sel_r, sel_next_s;
    logic [DATA_W-1:0] edit_val_r, edit_val_next_s;
    logic [TW-1:0]     timer_r, timer_next_s;
    logic [DATA_W-1:0] params_r [NUM_PARAMS];
    logic              edit_active_r, cfg_valid_r;
    logic [IW-1:0]     cfg_addr_r;
    logic [DATA_W-1:0] cfg_data_r;

    detent_stepper #(.COUNTS_PER_DETENT(COUNTS_PER_DETENT)) u_stepper (
        .clk      (clk),
        .rst_n    (rst_n),
        .position (position),
        .clear    (clear_s),
        .step_up  (step_up_s),
        .step_dn  (step_dn_s)
    );

    // Step decode, accumulator clear on state change, handshake detect.
    always_comb begin
        dir_s   = step_dir(step_up_s, step_dn_s);
        clear_s = (state_next_s != state_r);
        hs_s    = (state_r == ST_COMMIT) && cfg_valid_r && cfg.cfg_ready;
    end

    // Next-state logic; the button always takes precedence over a step.
    always_comb begin
        state_next_s    = state_r;
        sel_next_s      = sel_r;
        edit_val_next_s = edit_val_r;
        timer_next_s    = timer_r;
        case (state_r)
            ST_BROWSE: begin
                if (btn_pulse) begin
                    state_next_s    = ST_EDIT;
                    edit_val_next_s = params_r[sel_r];
                    timer_next_s    = {TW{1'b0}};
                end else begin
                    case (dir_s)
                        DIR_UP:  sel_next_s = (sel_r == IW'(NUM_PARAMS - 1)) ? {IW{1'b0}} : sel_r + IW'(1);
                        DIR_DN:  sel_next_s = (sel_r == {IW{1'b0}}) ? IW'(NUM_PARAMS - 1) : sel_r - IW'(1);
                        default: sel_next_s = sel_r;
                    endcase
                end
            end
            ST_EDIT: begin
                if (btn_pulse) begin
                    state_next_s = ST_COMMIT;
                    timer_next_s = {TW{1'b0}};
                end else if (dir_s == DIR_UP) begin
                    timer_next_s = {TW{1'b0}};
                    if (edit_val_r < DATA_W'(PARAM_MAX)) begin
                        edit_val_next_s = edit_val_r + DATA_W'(1);
                    end else begin
                        edit_val_next_s = edit_val_r;
                    end
                end else if (dir_s == DIR_DN) begin
                    timer_next_s = {TW{1'b0}};
                    if (edit_val_r != {DATA_W{1'b0}}) begin
                        edit_val_next_s = edit_val_r - DATA_W'(1);
                    end else begin
                        edit_val_next_s = edit_val_r;
                    end
                end else if (timer_r == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the edit; the bank is untouched.
                    state_next_s = ST_BROWSE;
                    timer_next_s = {TW{1'b0}};
                end else begin
                    timer_next_s = timer_r + TW'(1);
                end
            end
            ST_COMMIT: begin
                if (hs_s) begin
                    state_next_s = ST_BROWSE;
                end else begin
                    state_next_s = ST_COMMIT;
                end
            end
            default: begin
                state_next_s = ST_BROWSE;
            end
        endcase
    end

    // Sequencer state and registered status/cfg outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_BROWSE;
            sel_r         <= {IW{1'b0}};
            edit_val_r    <= {DATA_W{1'b0}};
            timer_r       <= {TW{1'b0}};
            edit_active_r <= 1'b0;
            cfg_valid_r   <= 1'b0;
            cfg_addr_r    <= {IW{1'b0}};
            cfg_data_r    <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_next_s;
            sel_r         <= sel_next_s;
            edit_val_r    <= edit_val_next_s;
            timer_r       <= timer_next_s;
            edit_active_r <= (state_next_s == ST_EDIT);
            cfg_valid_r   <= (state_next_s == ST_COMMIT);
            // Address/data are captured once on entry and held until accepted.
            if ((state_r == ST_EDIT) && (state_next_s == ST_COMMIT)) begin
                cfg_addr_r <= sel_r;
                cfg_data_r <= edit_val_r;
            end
        end
    end

    // Committed parameter bank, written only on an accepted cfg transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                params_r[i] <= {DATA_W{1'b0}};
            end
        end else if (hs_s) begin
            params_r[cfg_addr_r] <= cfg_data_r;
        end
    end

    // Output assembly from registered state.
    always_comb begin
        if (state_r == ST_EDIT) begin
            edit_value = edit_val_r;
        end else begin
            edit_value = params_r[sel_r];
        end
        param_bus = {(NUM_PARAMS * DATA_W){1'b0}};
        for (int i = 0; i < NUM_PARAMS; i++) begin
            param_bus[i*DATA_W +: DATA_W] = params_r[i];
        end
    end

    assign sel_index     = sel_r;
    assign edit_active   = edit_active_r;
    assign cfg.cfg_valid = cfg_valid_r;
    assign cfg.cfg_addr  = cfg_addr_r;
    assign cfg.cfg_data  = cfg_data_r;

endmodule

// File: tb/tb_encoder_param_controller.sv
// Self-checking bench for encoder_param_controller: a table of
// navigate/edit/commit records plus hand-written corner sequences, with
// a scoreboard queue of expected cfg writes.
module tb_encoder_param_controller;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int TO = 100;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [15:0]          position = 16'd0;
    logic                 btn_pulse = 1'b0;
    logic [IW-1:0]        sel_index;
    logic                 edit_active;
    logic [DW-1:0]        edit_value;
    logic [NP*DW-1:0]     param_bus;

    encoder_param_controller_if #(.IW(IW), .DATA_W(DW)) cfg_bus ();

    encoder_param_controller #(
        .NUM_PARAMS(NP), .DATA_W(DW), .PARAM_MAX(255),
        .COUNTS_PER_DETENT(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .position(position), .btn_pulse(btn_pulse),
        .sel_index(sel_index), .edit_active(edit_active), .edit_value(edit_value),
        .param_bus(param_bus), .cfg(cfg_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [IW-1:0] addr; logic [DW-1:0] data; } wr_t;
    wr_t sb[$];

    typedef struct { int nav; int edit; int gap; int delay; int exp_sel; int exp_val; } row_t;
    row_t rows[6];

    logic [DW-1:0] model [NP];
    logic [15:0]   pos = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input int counts, input int gap);
        int n;
        n = (counts < 0) ? -counts : counts;
        for (int i = 0; i < n; i++) begin
            if (counts > 0) pos = pos + 16'd1;
            else            pos = pos - 16'd1;
            position = pos;
            repeat (gap) tick();
        end
        repeat (3) tick();
    endtask

    task automatic press();
        btn_pulse = 1'b1;
        tick();
        btn_pulse = 1'b0;
    endtask

    function automatic logic [NP*DW-1:0] model_bus();
        logic [NP*DW-1:0] b;
        b = '0;
        for (int i = 0; i < NP; i++) b[i*DW +: DW] = model[i];
        return b;
    endfunction

    // Scoreboard: every accepted write must match the oldest expectation.
    always @(negedge clk) begin
        wr_t w;
        if (rst_n && cfg_bus.cfg_valid && cfg_bus.cfg_ready) begin
            chk("sb_write_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                w = sb.pop_front();
                chk("sb_addr", 32'(cfg_bus.cfg_addr), 32'(w.addr));
                chk("sb_data", 32'(cfg_bus.cfg_data), 32'(w.data));
            end
        end
    end

    initial begin
        cfg_bus.cfg_ready = 1'b0;
        for (int i = 0; i < NP; i++) model[i] = '0;
        rows[0] = '{nav: 4,  edit: 12,   gap: 10, delay: 0, exp_sel: 1, exp_val: 3};
        rows[1] = '{nav: 4,  edit: 12,   gap: 2,  delay: 5, exp_sel: 2, exp_val: 3};
        rows[2] = '{nav: 8,  edit: -8,   gap: 2,  delay: 1, exp_sel: 0, exp_val: 0};
        rows[3] = '{nav: -4, edit: 1016, gap: 2,  delay: 0, exp_sel: 3, exp_val: 254};
        rows[4] = '{nav: 0,  edit: 12,   gap: 2,  delay: 2, exp_sel: 3, exp_val: 255};
        rows[5] = '{nav: 4,  edit: 8,    gap: 2,  delay: 0, exp_sel: 0, exp_val: 2};

        // Reset state
        repeat (2) tick();
        chk("rst_sel", 32'(sel_index), 32'd0);
        chk("rst_edit_active", 32'(edit_active), 32'd0);
        chk("rst_edit_value", 32'(edit_value), 32'd0);
        chk("rst_param_bus", param_bus, 32'd0);
        chk("rst_cfg_valid", 32'(cfg_bus.cfg_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 6; r++) begin
            move(rows[r].nav, rows[r].gap);
            chk("nav_sel", 32'(sel_index), 32'(rows[r].exp_sel));
            chk("nav_no_valid", 32'(cfg_bus.cfg_valid), 32'd0);
            press();
            chk("edit_enter", 32'(edit_active), 32'd1);
            chk("edit_load", 32'(edit_value), 32'(model[rows[r].exp_sel]));
            move(rows[r].edit, rows[r].gap);
            chk("edit_value", 32'(edit_value), 32'(rows[r].exp_val));
            press();
            chk("commit_valid", 32'(cfg_bus.cfg_valid), 32'd1);
            chk("commit_addr", 32'(cfg_bus.cfg_addr), 32'(rows[r].exp_sel));
            chk("commit_data", 32'(cfg_bus.cfg_data), 32'(rows[r].exp_val));
            sb.push_back('{addr: IW'(rows[r].exp_sel), data: DW'(rows[r].exp_val)});
            for (int d = 0; d < rows[r].delay; d++) begin
                tick();
                chk("hold_valid", 32'(cfg_bus.cfg_valid), 32'd1);
                chk("hold_addr", 32'(cfg_bus.cfg_addr), 32'(rows[r].exp_sel));
                chk("hold_data", 32'(cfg_bus.cfg_data), 32'(rows[r].exp_val));
            end
            cfg_bus.cfg_ready = 1'b1;
            tick();
            cfg_bus.cfg_ready = 1'b0;
            model[rows[r].exp_sel] = DW'(rows[r].exp_val);
            chk("hs_valid_low", 32'(cfg_bus.cfg_valid), 32'd0);
            chk("hs_edit_inactive", 32'(edit_active), 32'd0);
            chk("hs_param_bus", param_bus, model_bus());
            chk("hs_edit_value", 32'(edit_value), 32'(rows[r].exp_val));
        end

        // Step latency: count at N, sel changes at N+2 (sel 0 -> 1)
        move(3, 2);
        pos = pos + 16'd1;
        position = pos;
        tick();
        chk("lat_n1_sel", 32'(sel_index), 32'd0);
        tick();
        chk("lat_n2_sel", 32'(sel_index), 32'd1);
        repeat (2) tick();

        // Button coincident with a step in BROWSE: step dropped
        move(3, 2);
        pos = pos + 16'd1;
        position = pos;
        tick();
        press();
        chk("coinc_edit", 32'(edit_active), 32'd1);
        chk("coinc_sel", 32'(sel_index), 32'd1);
        chk("coinc_value", 32'(edit_value), 32'(model[1]));
        repeat (3) tick();
        chk("coinc_sel_later", 32'(sel_index), 32'd1);
        press();
        sb.push_back('{addr: IW'(1), data: model[1]});
        cfg_bus.cfg_ready = 1'b1;
        tick();
        cfg_bus.cfg_ready = 1'b0;
        chk("coinc_bus", param_bus, model_bus());

        // Edit timeout: abandoned with no write
        press();
        move(4, 2);
        chk("to_edit_value", 32'(edit_value), 32'(model[1] + 8'd1));
        repeat (96) tick();
        chk("to_still_edit", 32'(edit_active), 32'd1);
        tick();
        chk("to_expired", 32'(edit_active), 32'd0);
        chk("to_no_valid", 32'(cfg_bus.cfg_valid), 32'd0);
        chk("to_value_kept", 32'(edit_value), 32'(model[1]));
        chk("to_bus_kept", param_bus, model_bus());

        // Reset mid-COMMIT
        press();
        press();
        chk("rc_valid", 32'(cfg_bus.cfg_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NP; i++) model[i] = '0;
        chk("rc_valid_low", 32'(cfg_bus.cfg_valid), 32'd0);
        chk("rc_edit_active", 32'(edit_active), 32'd0);
        chk("rc_sel", 32'(sel_index), 32'd0);
        chk("rc_edit_value", 32'(edit_value), 32'd0);
        chk("rc_bus", param_bus, model_bus());
        chk("rc_addr", 32'(cfg_bus.cfg_addr), 32'd0);
        chk("rc_data", 32'(cfg_bus.cfg_data), 32'd0);

        // Position wrap 0x7FFE -> 0x8002 gives exactly one up-step
        pos = 16'h7FFE;
        position = pos;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        move(4, 2);
        chk("wrap_sel", 32'(sel_index), 32'd1);
        repeat (4) tick();
        chk("wrap_sel_stable", 32'(sel_index), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
